// File: rtl/fft16_pkg.sv
// Shared types and helpers for the 16-point FFT frame sequencer.
package fft16_pkg;

    localparam int unsigned DEF_N_POINTS = 16;
    localparam int unsigned DEF_LOG2N    = 4;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Mirror the index bits: position p maps to result slot bitrev(p).
    function automatic logic [DEF_LOG2N-1:0] bitrev(input logic [DEF_LOG2N-1:0] v);
        logic [DEF_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DEF_LOG2N); i++) begin
            r[i] = v[int'(DEF_LOG2N) - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft16_sequencer_if.sv
// Handshake, enable and status bundle between the sequencer and the FFT pipeline.
interface fft16_sequencer_if
    import fft16_pkg::*;
#(
    parameter int unsigned LOG2N      = DEF_LOG2N,
    parameter int unsigned NUM_STAGES = 4
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic                  load_en;
    logic [LOG2N-1:0]      load_idx;
    logic [NUM_STAGES-1:0] stage_en;
    logic                  out_valid;
    logic [LOG2N-1:0]      out_idx;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    modport master (
        input  in_valid, out_ready,
        output in_ready, load_en, load_idx, stage_en, out_valid, out_idx, busy, done
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, load_en, load_idx, stage_en, out_valid, out_idx, busy, done
    );

endinterface

// File: rtl/fft16_frame_counter.sv
// Wrapping frame counter with synchronous clear and a terminal-count flag.
module fft16_frame_counter
    import fft16_pkg::*;
#(
    parameter int unsigned W   = DEF_LOG2N,
    parameter int unsigned MAX = DEF_N_POINTS - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         last_c
);

    // Clear wins over increment; the power-of-two frame size makes wrap free.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign last_c = (count == W'(MAX));

endmodule

// File: rtl/fft16_sequencer.sv
// Frame controller: loads 16 samples, pulses butterfly stage enables, drains results.
module fft16_sequencer
    import fft16_pkg::*;
#(
    parameter int unsigned N_POINTS   = DEF_N_POINTS,
    parameter int unsigned LOG2N      = DEF_LOG2N,
    parameter int unsigned NUM_STAGES = 4,
    parameter bit          BIT_REV    = 1'b1
) (
    input logic               clk,
    input logic               rst,
    fft16_sequencer_if.master bus
);

    localparam int unsigned KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    state_t                state;
    state_t                state_nx;
    logic [KW-1:0]         k;
    logic [KW-1:0]         k_nx;
    logic [NUM_STAGES-1:0] stage_nx;
    logic [NUM_STAGES-1:0] stage_q;
    logic                  done_nx;
    logic                  done_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic                  load_fire;
    logic                  load_last;
    logic                  xfer;
    logic                  drain_last;
    logic [LOG2N-1:0]      load_cnt;
    logic [LOG2N-1:0]      pos;

    assign load_fire = bus.in_valid & in_ready_q;
    assign xfer      = out_valid_q & bus.out_ready;

    fft16_frame_counter #(
        .W   (LOG2N),
        .MAX (N_POINTS - 1)
    ) u_load_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (load_fire),
        .clear  (state != LOAD),
        .count  (load_cnt),
        .last_c (load_last)
    );

    // Drain position is zeroed while computing so DRAIN always opens at p=0.
    fft16_frame_counter #(
        .W   (LOG2N),
        .MAX (N_POINTS - 1)
    ) u_drain_pos (
        .clk    (clk),
        .rst    (rst),
        .inc    (xfer),
        .clear  (state == COMPUTE),
        .count  (pos),
        .last_c (drain_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            k           <= '0;
            stage_q     <= '0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            k           <= k_nx;
            stage_q     <= stage_nx;
            done_q      <= done_nx;
            in_ready_q  <= (state_nx == LOAD);
            out_valid_q <= (state_nx == DRAIN);
            busy_q      <= (state_nx != LOAD);
        end
    end

    // Next-state plus the next value of each registered strobe.
    always_comb begin
        state_nx = state;
        k_nx     = k;
        stage_nx = '0;
        done_nx  = 1'b0;
        unique case (state)
            LOAD: begin
                if (load_fire && load_last) begin
                    state_nx = COMPUTE;
                    k_nx     = '0;
                    stage_nx = NUM_STAGES'(1);
                end
            end
            COMPUTE: begin
                if (k == KW'(NUM_STAGES - 1)) begin
                    state_nx = DRAIN;
                end else begin
                    k_nx     = k + KW'(1);
                    stage_nx = NUM_STAGES'(1) << k_nx;
                end
            end
            DRAIN: begin
                if (xfer && drain_last) begin
                    state_nx = LOAD;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = LOAD;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.load_en   = load_fire;
    assign bus.load_idx  = load_cnt;
    assign bus.stage_en  = stage_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    generate
        if (BIT_REV) begin : g_rev
            assign bus.out_idx = bitrev(pos);
        end else begin : g_nat
            assign bus.out_idx = pos;
        end
    endgenerate

endmodule

// File: doc/fft16_sequencer.md
Name: fft16_sequencer

Overview:
- Frame-level controller for the 16-point FFT pipeline.
- Accepts a serial stream of 16 complex samples into the input buffer and reports which slot each sample goes to.
- Pulses the per-stage `en` inputs of the butterfly stages in order; the second stage is the eight-point butterfly pair.
- Then steps the output serializer through the 16 results, bit-reversed, under a valid/ready handshake.
- Contains no arithmetic datapath; it only produces enables, indices and status.

Parameters:
- N_POINTS, 16: samples per frame; must be a power of two.
- LOG2N, 4: log2(N_POINTS); width of load_idx and out_idx.
- NUM_STAGES, 4: number of butterfly stage enables, stage_en[0] first.
- BIT_REV, 1: 1 means out_idx walks bit-reversed order; 0 means natural order.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream sample present this cycle.
- in_ready  output  1  sequencer can accept a sample; a sample is accepted when in_valid & in_ready.
- load_en  output  1  write strobe to the input buffer; equals in_valid & in_ready (combinational).
- load_idx  output  LOG2N  buffer slot for the sample being accepted.
- stage_en  output  NUM_STAGES  one-hot, one-cycle enables; drive each stage's `en`.
- out_valid  output  1  the output serializer presents result out_idx.
- out_idx  output  LOG2N  result index selected by the output serializer.
- out_ready  input  1  downstream accepts the result; transfer happens when out_valid & out_ready.
- busy  output  1  high in COMPUTE and DRAIN.
- done  output  1  one-cycle pulse after the last result transfers.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- All state is registered except load_en, which is combinational.
- Reset state: LOAD with all counters 0. in_ready=1 (derived from state). stage_en=0, out_valid=0, out_idx=0, busy=0, done=0, load_idx=0.
- States: LOAD, COMPUTE, DRAIN.
- LOAD:
  - in_ready=1.
  - load_idx = sample count.
  - Each accepted sample increments the count.
  - The accept at count N_POINTS-1: wrap count to 0, go to COMPUTE.
  - No sample is dropped; in_valid while in_ready=0 is simply not accepted. Upstream must hold the sample.
- COMPUTE:
  - in_ready=0, busy=1.
  - A stage counter k runs 0..NUM_STAGES-1; stage_en = 1<<k, one stage per cycle.
  - After k = NUM_STAGES-1: go to DRAIN with out_idx set for position 0.
- Timing: if the 16th sample is accepted at edge E:
  - stage_en[0] is high in the cycle after E.
  - stage_en[NUM_STAGES-1] is high NUM_STAGES cycles after E.
  - out_valid first rises NUM_STAGES+1 cycles after E.
- DRAIN:
  - out_valid=1, busy=1.
  - Output position p runs 0..N_POINTS-1.
  - out_idx = bitrev(p) if BIT_REV, else p.
  - p advances only on out_valid & out_ready. When out_ready=0, out_idx and out_valid hold.
  - Transfer at p = N_POINTS-1: the next cycle has out_valid=0, done=1, state LOAD, in_ready=1.
- done is high for exactly one cycle per frame. busy is 0 in that done cycle.
- in_valid during COMPUTE or DRAIN has no effect; load_en=0.
- Reset mid-operation, any state: next cycle is the reset state.
  - Partially loaded or drained frames are abandoned.
  - No stage_en or done pulse is emitted for them.
- stage_en is never high while load_en or out_valid is high.

Decomposition:
- Package fft16_pkg holds:
  - the state enum {LOAD, COMPUTE, DRAIN};
  - the N_POINTS / LOG2N defaults;
  - a pure function bitrev(LOG2N-bit).
- One sub-module: fft16_frame_counter.
  - LOG2N-bit counter with inc and clear inputs and a terminal-count output.
  - Instantiated twice: load count and drain position.
- The stage counter stays inline.

Test Plan:
- Reset then 16 back-to-back in_valid, out_ready=1 -> load_idx 0..15 with load_en each cycle; stage_en = 0001, 0010, 0100, 1000 on the 4 cycles after the 16th accept; out_idx 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 on consecutive cycles; done high one cycle; in_ready back to 1.
- in_valid gapped (1,0,1,0,...) -> load_idx advances only on accepted cycles; COMPUTE starts the cycle after the 16th accept.
- Backpressure: out_ready=0 for 3 cycles at p=5 -> out_idx holds 10 with out_valid=1; resumes at 6 when out_ready=1; no index skipped or repeated.
- in_valid held high throughout COMPUTE/DRAIN -> in_ready=0, load_en=0; the next frame starts at load_idx=0 only after done.
- rst asserted at load count 9, and again at stage_en=0100 and at drain p=7 -> next cycle is the full reset state; no done pulse; the following frame runs normally from index 0.
- BIT_REV=0 build -> out_idx 0..15 in natural order.
